// File: rtl/button_event_parser.sv
// Multi-channel button front end: per-channel two-flop synchronizer,
// tick-sampled saturating debouncer and a press / release / long-press /
// auto-repeat event FSM. All channels share one free-running sample tick.
// The release and repeat outputs are named release_pulse and repeat_pulse
// because "release" and "repeat" are reserved words in SystemVerilog.
module button_event_parser #(
    parameter int SIGNAL_WIDTH     = 1,
    parameter int SAMPLE_CNT_MAX   = 62500,
    parameter int PULSE_CNT_MAX    = 200,
    parameter int LONG_PRESS_TICKS = 25000,
    parameter int REPEAT_TICKS     = 5000,
    parameter int REPEAT_EN        = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIGNAL_WIDTH-1:0] in,
    output logic [SIGNAL_WIDTH-1:0] level,
    output logic [SIGNAL_WIDTH-1:0] press,
    output logic [SIGNAL_WIDTH-1:0] release_pulse,
    output logic [SIGNAL_WIDTH-1:0] long_press,
    output logic [SIGNAL_WIDTH-1:0] repeat_pulse
);

    localparam int TW   = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int DW   = $clog2(PULSE_CNT_MAX + 1);
    localparam int HMAX = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT_MAX - 1);
    localparam logic [DW-1:0] D_MAX     = DW'(PULSE_CNT_MAX);
    localparam logic [HW-1:0] H_LONG    = HW'(LONG_PRESS_TICKS);
    localparam logic [HW-1:0] H_REP     = HW'(REPEAT_TICKS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    logic [SIGNAL_WIDTH-1:0] sync1;
    logic [SIGNAL_WIDTH-1:0] sync2;
    logic [TW-1:0]           tick_cnt;
    logic                    tick;
    logic [DW-1:0]           dcnt     [SIGNAL_WIDTH];
    logic [DW-1:0]           dcnt_nxt [SIGNAL_WIDTH];
    logic [1:0]              state    [SIGNAL_WIDTH];
    logic [HW-1:0]           hcnt     [SIGNAL_WIDTH];
    logic [HW-1:0]           hcnt_inc [SIGNAL_WIDTH];

    // Two-flop synchronizer bringing the raw buttons into the clk domain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, giving a true 2-stage lag.
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // Free-running sample-tick divider shared by every channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Next debounce count: cleared by any low sample, counts high ticks up to saturation.
    always_comb begin
        for (int i = 0; i < SIGNAL_WIDTH; i++) begin
            // NOTE: default first, so no path leaves dcnt_nxt unassigned and no latch is inferred.
            dcnt_nxt[i] = dcnt[i];
            if (!sync2[i]) begin
                dcnt_nxt[i] = '0;
            end else if (tick && (dcnt[i] != D_MAX)) begin
                dcnt_nxt[i] = dcnt[i] + 1'b1;
            end
        end
    end

    // Debounce counters and debounced level; level always equals (dcnt == max).
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIGNAL_WIDTH; i++) begin
            // NOTE: these per-channel arrays are control state, not storage,
            // so every element is reset explicitly inside the loop.
            if (rst) begin
                dcnt[i]  <= '0;
                level[i] <= 1'b0;
            end else begin
                dcnt[i]  <= dcnt_nxt[i];
                level[i] <= (dcnt_nxt[i] == D_MAX);
            end
        end
    end

    // Incremented hold count used for the threshold compares.
    always_comb begin
        for (int i = 0; i < SIGNAL_WIDTH; i++) begin
            hcnt_inc[i] = hcnt[i] + 1'b1;
        end
    end

    // Event FSM per channel; a falling level has priority over any tick threshold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SIGNAL_WIDTH; i++) begin
            press[i]         <= 1'b0;
            release_pulse[i] <= 1'b0;
            long_press[i]    <= 1'b0;
            repeat_pulse[i]  <= 1'b0;
            if (rst) begin
                state[i] <= ST_IDLE;
                hcnt[i]  <= '0;
            end else begin
                case (state[i])
                    ST_IDLE: begin
                        if (level[i]) begin
                            press[i] <= 1'b1;
                            hcnt[i]  <= '0;
                            state[i] <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (!level[i]) begin
                            release_pulse[i] <= 1'b1;
                            hcnt[i]          <= '0;
                            state[i]         <= ST_IDLE;
                        end else if (tick) begin
                            if (hcnt_inc[i] == H_LONG) begin
                                long_press[i] <= 1'b1;
                                hcnt[i]       <= '0;
                                state[i]      <= ST_LONG;
                            end else begin
                                hcnt[i] <= hcnt_inc[i];
                            end
                        end
                    end
                    ST_LONG: begin
                        if (!level[i]) begin
                            release_pulse[i] <= 1'b1;
                            hcnt[i]          <= '0;
                            state[i]         <= ST_IDLE;
                        end else if (tick) begin
                            if (hcnt_inc[i] == H_REP) begin
                                repeat_pulse[i] <= (REPEAT_EN != 0);
                                hcnt[i]         <= '0;
                            end else begin
                                hcnt[i] <= hcnt_inc[i];
                            end
                        end
                    end
                    default: begin
                        state[i] <= ST_IDLE;
                        hcnt[i]  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_event_parser.sv
// Self-checking bench for button_event_parser: two instances (repeat enabled
// and disabled) share stimulus; a cycle-indexed reference derived from the
// input history predicts every output on every cycle.
module tb_button_event_parser;

    localparam int SW      = 4;
    localparam int S_MAX   = 4;
    localparam int P_MAX   = 3;
    localparam int L_TICKS = 5;
    localparam int R_TICKS = 2;
    localparam int MAXE    = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [SW-1:0] in_sig;
    logic [SW-1:0] level_a, press_a, release_a, long_a, rep_a;
    logic [SW-1:0] level_b, press_b, release_b, long_b, rep_b;

    button_event_parser #(
        .SIGNAL_WIDTH(SW), .SAMPLE_CNT_MAX(S_MAX), .PULSE_CNT_MAX(P_MAX),
        .LONG_PRESS_TICKS(L_TICKS), .REPEAT_TICKS(R_TICKS), .REPEAT_EN(1)
    ) dut_a (
        .clk(clk), .rst(rst), .in(in_sig), .level(level_a), .press(press_a),
        .release_pulse(release_a), .long_press(long_a), .repeat_pulse(rep_a)
    );

    button_event_parser #(
        .SIGNAL_WIDTH(SW), .SAMPLE_CNT_MAX(S_MAX), .PULSE_CNT_MAX(P_MAX),
        .LONG_PRESS_TICKS(L_TICKS), .REPEAT_TICKS(R_TICKS), .REPEAT_EN(0)
    ) dut_b (
        .clk(clk), .rst(rst), .in(in_sig), .level(level_b), .press(press_b),
        .release_pulse(release_b), .long_press(long_b), .repeat_pulse(rep_b)
    );

    wire [39:0] obs = {level_a, press_a, release_a, long_a, rep_a,
                       level_b, press_b, release_b, long_b, rep_b};

    int checks = 0;
    int errors = 0;
    int e = 0;                       // cycle index since the last reset edge
    logic [SW-1:0] in_at [MAXE];     // input value driven during cycle j
    logic [SW-1:0] lv    [MAXE];     // expected debounced level in cycle j
    logic [SW-1:0] x_level, x_press, x_release, x_long, x_rep;
    logic [39:0]   exp_vec;

    function automatic bit sync_at(int j, int ch);
        if (j < 2) return 1'b0;
        return in_at[j-2][ch];
    endfunction

    function automatic bit is_tick(int j);
        return (j % S_MAX) == (S_MAX - 1);
    endfunction

    // Level in cycle c: at least P_MAX ticks fell inside the unbroken
    // high run of the synchronized input that ends in cycle c-1.
    function automatic bit level_at(int c, int ch);
        int k = 0;
        for (int j = c - 1; j >= 0; j--) begin
            if (!sync_at(j, ch)) break;
            if (is_tick(j)) k++;
            if (k >= P_MAX) break;
        end
        return k >= P_MAX;
    endfunction

    // Drive one cycle of inputs, advance to just after the next edge and
    // derive the expected outputs for the new cycle.
    task automatic step(input logic [SW-1:0] v, input logic r);
        in_sig = v;
        rst    = r;
        in_at[e] = v;
        @(posedge clk);
        #1;
        if (r) e = 0;
        else   e = e + 1;
        if (e >= MAXE) begin
            $display("FAIL epoch_overflow cyc=%0d limit=%0d", e, MAXE);
            $fatal(1, "epoch overflow");
        end
        for (int ch = 0; ch < SW; ch++) begin
            lv[e][ch]      = (e == 0) ? 1'b0 : level_at(e, ch);
            x_press[ch]    = (e >= 2) && lv[e-1][ch] && !lv[e-2][ch];
            x_release[ch]  = (e >= 2) && !lv[e-1][ch] && lv[e-2][ch];
            x_long[ch]     = 1'b0;
            x_rep[ch]      = 1'b0;
            if (e >= 1 && lv[e-1][ch] && is_tick(e-1)) begin
                int rc = e - 1;
                int n  = 0;
                while (rc > 0 && lv[rc-1][ch]) rc--;
                for (int j = rc + 1; j <= e - 1; j++) if (is_tick(j)) n++;
                x_long[ch] = (n == L_TICKS);
                x_rep[ch]  = (n > L_TICKS) && (((n - L_TICKS) % R_TICKS) == 0);
            end
        end
        x_level = lv[e];
        exp_vec = {x_level, x_press, x_release, x_long, x_rep,
                   x_level, x_press, x_release, x_long, 4'b0000};
    endtask

    task automatic test_reset();
        step('0, 1'b1);
        if (obs !== 40'h0) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs, 40'h0);
        end
        checks++;
        for (int i = 0; i < 20; i++) begin
            step(4'hF, 1'b1);
            if (obs !== 40'h0) begin
                errors++;
                $display("FAIL reset_held cyc=%0d got=%h want=%h", i, obs, 40'h0);
            end
            checks++;
        end
        for (int i = 0; i < 10; i++) begin
            step('0, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_hold();
        int t_edge;
        int t_rise = -1;
        int t_long = -1;
        int t_last = -1;
        int n_press = 0;
        int n_rep = 0;
        int bad_gap = 0;
        step('0, 1'b1);
        step('0, 1'b0);
        step('0, 1'b0);
        t_edge = e;
        for (int i = 0; i < 200; i++) begin
            step(4'b0001, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL hold_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (level_a[0] && t_rise < 0) t_rise = e;
            if (press_a[0]) n_press++;
            if (long_a[0]) t_long = e;
            if (rep_a[0]) begin
                if ((t_last < 0) ? (e - t_long != 8) : (e - t_last != 8)) bad_gap++;
                t_last = e;
                n_rep++;
            end
        end
        if (t_rise < 0 || (t_rise - t_edge) > 17) begin
            errors++;
            $display("FAIL hold_rise_latency got=%0d want<=17", t_rise - t_edge);
        end
        checks++;
        if (n_press != 1) begin
            errors++;
            $display("FAIL hold_press_count got=%0d want=1", n_press);
        end
        checks++;
        if (t_long - t_rise != 20) begin
            errors++;
            $display("FAIL hold_long_delay got=%0d want=20", t_long - t_rise);
        end
        checks++;
        if (n_rep < 15 || bad_gap != 0) begin
            errors++;
            $display("FAIL hold_repeat got=%0d pulses %0d bad gaps want>=15 pulses 0 bad gaps", n_rep, bad_gap);
        end
        checks++;
        for (int i = 0; i < 20; i++) begin
            step('0, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL hold_release cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
        end
    endtask

    task automatic test_bounce();
        int act = 0;
        step('0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step(((i / 3) % 2) ? 4'b0001 : 4'b0000, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (level_a[0] | press_a[0] | release_a[0] | level_b[0] | press_b[0] | release_b[0]) act++;
        end
        if (act != 0) begin
            errors++;
            $display("FAIL bounce_activity got=%0d want=0", act);
        end
        checks++;
    endtask

    task automatic test_short_hold();
        int t_rise = -1;
        int fall_t = -1;
        int rel_t = -1;
        int n_long = 0;
        int n_rel = 0;
        step('0, 1'b1);
        for (int i = 0; i < 40 && t_rise < 0; i++) begin
            step(4'b0001, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL short_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (level_a[0]) t_rise = e;
        end
        if (t_rise < 0) begin
            errors++;
            $display("FAIL short_rise_timeout got=none want=level within 40 cycles");
        end
        checks++;
        for (int i = 0; i < 40; i++) begin
            step((i < 10) ? 4'b0001 : 4'b0000, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL short_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (!level_a[0] && fall_t < 0) fall_t = e;
            if (release_a[0]) begin rel_t = e; n_rel++; end
            if (long_a[0] || long_b[0]) n_long++;
        end
        if (n_long != 0 || n_rel != 1) begin
            errors++;
            $display("FAIL short_pulses got=%0d long %0d release want=0 long 1 release", n_long, n_rel);
        end
        checks++;
        if (fall_t < 0 || rel_t != fall_t + 1) begin
            errors++;
            $display("FAIL short_release_timing got=%0d want=%0d", rel_t, fall_t + 1);
        end
        checks++;
    endtask

    task automatic test_release_at_threshold();
        int t_rise = -1;
        int t1;
        int j;
        int fall_t = -1;
        int n_long = 0;
        int n_rel = 0;
        step('0, 1'b1);
        for (int i = 0; i < 40 && t_rise < 0; i++) begin
            step(4'b0001, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL thresh_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (x_level[0]) t_rise = e;
        end
        if (t_rise < 0) begin
            errors++;
            $display("FAIL thresh_rise_timeout got=none want=level within 40 cycles");
            t_rise = e;
        end
        checks++;
        // Cycle of the LONG_PRESS_TICKS-th tick counted after the rise.
        t1 = t_rise + 1;
        while (!is_tick(t1)) t1++;
        j = t1 + S_MAX * (L_TICKS - 1);
        while (e < j - 3) begin
            step(4'b0001, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL thresh_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (long_a[0] || long_b[0]) n_long++;
        end
        for (int i = 0; i < 30; i++) begin
            step('0, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL thresh_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (!level_a[0] && fall_t < 0) fall_t = e;
            if (release_a[0]) n_rel++;
            if (long_a[0] || long_b[0]) n_long++;
        end
        if (fall_t != j) begin
            errors++;
            $display("FAIL thresh_alignment got=%0d want=%0d", fall_t, j);
        end
        checks++;
        if (n_long != 0 || n_rel != 1) begin
            errors++;
            $display("FAIL thresh_release_wins got=%0d long %0d release want=0 long 1 release", n_long, n_rel);
        end
        checks++;
    endtask

    task automatic test_reset_mid_hold();
        bit got_long = 1'b0;
        int n_press = 0;
        int n_rel = 0;
        step('0, 1'b1);
        for (int i = 0; i < 120 && !got_long; i++) begin
            step(4'b0010, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL midrst_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (long_a[1]) got_long = 1'b1;
        end
        if (!got_long) begin
            errors++;
            $display("FAIL midrst_long_timeout got=none want=long_press within 120 cycles");
        end
        checks++;
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        if (obs !== 40'h0) begin
            errors++;
            $display("FAIL midrst_outputs got=%h want=%h", obs, 40'h0);
        end
        checks++;
        for (int i = 0; i < 40; i++) begin
            step(4'b0010, 1'b0);
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL midrst_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
            if (press_a[1]) n_press++;
            if (release_a[1] || release_b[1]) n_rel++;
        end
        if (n_press != 1 || n_rel != 0) begin
            errors++;
            $display("FAIL midrst_repress got=%0d press %0d release want=1 press 0 release", n_press, n_rel);
        end
        checks++;
        for (int i = 0; i < 10; i++) step('0, 1'b0);
    endtask

    task automatic test_channels();
        for (int rnd = 0; rnd < 3; rnd++) begin
            int start [SW];
            int dur   [SW];
            int np    [SW];
            int nr    [SW];
            int rep_b_seen = 0;
            logic [SW-1:0] v;
            for (int ch = 0; ch < SW; ch++) begin
                start[ch] = ch * 12 + int'($urandom_range(0, 8));
                dur[ch]   = int'($urandom_range(30, 150));
                np[ch]    = 0;
                nr[ch]    = 0;
            end
            step('0, 1'b1);
            for (int i = 0; i < 260; i++) begin
                for (int ch = 0; ch < SW; ch++) v[ch] = (i >= start[ch]) && (i < start[ch] + dur[ch]);
                step(v, 1'b0);
                if (obs !== exp_vec) begin
                    errors++;
                    $display("FAIL chan_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
                end
                checks++;
                for (int ch = 0; ch < SW; ch++) begin
                    if (press_a[ch] && press_b[ch]) np[ch]++;
                    if (release_a[ch] && release_b[ch]) nr[ch]++;
                end
                if (rep_b != '0) rep_b_seen++;
            end
            for (int ch = 0; ch < SW; ch++) begin
                if (np[ch] != 1 || nr[ch] != 1) begin
                    errors++;
                    $display("FAIL chan_events ch=%0d got=%0d press %0d release want=1 press 1 release", ch, np[ch], nr[ch]);
                end
                checks++;
            end
            if (rep_b_seen != 0) begin
                errors++;
                $display("FAIL chan_repeat_disabled got=%0d want=0", rep_b_seen);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int hold [SW];
        logic [SW-1:0] cur = '0;
        for (int ch = 0; ch < SW; ch++) hold[ch] = 0;
        step('0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < SW; ch++) begin
                if (hold[ch] == 0) begin
                    cur[ch]  = ~cur[ch];
                    hold[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                                           : int'($urandom_range(20, 120));
                end
                hold[ch]--;
            end
            step(cur, ($urandom_range(0, 499) == 0));
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", e, obs, exp_vec);
            end
            checks++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        in_sig = '0;
        test_reset();
        test_hold();
        test_bounce();
        test_short_hold();
        test_release_at_threshold();
        test_reset_mid_hold();
        test_channels();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
